// File: rtl/policy_argmax_pipe.sv
// Two-stage signed argmax over four Q-values with epsilon-greedy exploration
// driven by an on-chip 16-bit Fibonacci LFSR.
module policy_argmax_pipe #(
    parameter int          DW        = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] q0,
    input  logic signed [DW-1:0] q1,
    input  logic signed [DW-1:0] q2,
    input  logic signed [DW-1:0] q3,
    input  logic                 explore_en,
    input  logic [7:0]           epsilon,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           action,
    output logic signed [DW-1:0] qmax,
    output logic [1:0]           greedy_action,
    output logic                 explored
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0]          lfsr;
    logic [15:0]          lfsr_next;
    logic                 s1_valid;
    logic signed [DW-1:0] s1_m01;
    logic signed [DW-1:0] s1_m23;
    logic [1:0]           s1_i01;
    logic [1:0]           s1_i23;
    logic                 s1_explore_en;
    logic [7:0]           s1_epsilon;
    logic [15:0]          s1_lfsr;

    logic                 advance1;
    logic                 advance2;
    logic                 accept;

    logic signed [DW-1:0] m01;
    logic signed [DW-1:0] m23;
    logic [1:0]           i01;
    logic [1:0]           i23;
    logic signed [DW-1:0] qmax_d;
    logic [1:0]           greedy_d;
    logic                 explore_d;
    logic [1:0]           action_d;

    // Handshake: a beat moves on a clock edge where valid && ready. Each stage
    // advances when its successor is empty or being drained this cycle, so
    // in_ready depends only on registered valids and out_ready, never in_valid.
    assign advance2 = !out_valid || out_ready;
    assign advance1 = !s1_valid || advance2;
    assign in_ready = advance1;
    assign accept   = in_valid && in_ready;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Ties keep the lower index: the higher one must be strictly greater.
    always_comb begin
        m01 = q0;
        i01 = 2'd0;
        m23 = q2;
        i23 = 2'd2;
        if (q1 > q0) begin
            m01 = q1;
            i01 = 2'd1;
        end
        if (q3 > q2) begin
            m23 = q3;
            i23 = 2'd3;
        end
    end

    always_comb begin
        qmax_d    = s1_m01;
        greedy_d  = s1_i01;
        if (s1_m23 > s1_m01) begin
            qmax_d   = s1_m23;
            greedy_d = s1_i23;
        end
        explore_d = s1_explore_en && (s1_lfsr[7:0] < s1_epsilon);
        action_d  = explore_d ? s1_lfsr[9:8] : greedy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else if (accept) begin
            lfsr <= lfsr_next;
        end
    end

    // Stage 1 captures the pre-advance LFSR value alongside the pair maxima.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_m01        <= '0;
            s1_m23        <= '0;
            s1_i01        <= 2'd0;
            s1_i23        <= 2'd0;
            s1_explore_en <= 1'b0;
            s1_epsilon    <= 8'd0;
            s1_lfsr       <= 16'd0;
        end else if (advance1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_m01        <= m01;
                s1_m23        <= m23;
                s1_i01        <= i01;
                s1_i23        <= i23;
                s1_explore_en <= explore_en;
                s1_epsilon    <= epsilon;
                s1_lfsr       <= lfsr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            qmax          <= '0;
            greedy_action <= 2'd0;
            action        <= 2'd0;
            explored      <= 1'b0;
        end else if (advance2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                qmax          <= qmax_d;
                greedy_action <= greedy_d;
                action        <= action_d;
                explored      <= explore_d;
            end
        end
    end

endmodule

// File: tb/tb_policy_argmax_pipe.sv
// Directed bench for policy_argmax_pipe: hand-computed greedy results, an LFSR
// reference for exploration, and an in-order expected queue.
module tb_policy_argmax_pipe;
  localparam int          DW   = 32;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          EW   = DW + 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] q0 = '0;
  logic signed [DW-1:0] q1 = '0;
  logic signed [DW-1:0] q2 = '0;
  logic signed [DW-1:0] q3 = '0;
  logic                 explore_en = 1'b0;
  logic [7:0]           epsilon = 8'd0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [1:0]           action;
  logic signed [DW-1:0] qmax;
  logic [1:0]           greedy_action;
  logic                 explored;

  // clock / reset
  always #5 clk = ~clk;

  policy_argmax_pipe #(.DW(DW), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .explore_en(explore_en), .epsilon(epsilon),
    .out_valid(out_valid), .out_ready(out_ready),
    .action(action), .qmax(qmax), .greedy_action(greedy_action),
    .explored(explored)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_out = 0;
  int last_lat = 0;
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  logic [15:0]   mdl_lfsr = SEED;
  logic [DW-1:0] cur_qmax = '0;
  logic [1:0]    cur_greedy = 2'd0;
  logic          stall_prev = 1'b0;
  logic          saw_block = 1'b0;
  logic [EW-1:0] snap = '0;
  logic [EW-1:0] last_out = '0;

  int tq[6][4] = '{'{1, 2, 3, 4}, '{10, -5, 7, 10}, '{-7, -2, -9, -3},
                   '{0, 0, 5, 0}, '{100, 200, -300, 50}, '{-100, -100, -100, -99}};
  int tm[6] = '{4, 10, -2, 5, 200, -99};
  logic [1:0] tg[6] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3};

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard + driver step: sample at negedge, then pass the rising edge
  task automatic tick(output bit acc);
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    logic          ex;
    logic [1:0]    a;
    acc = 1'b0;
    @(negedge clk);
    o = {qmax, greedy_action, action, explored};
    if (stall_prev) check_eq("hold", 64'(o), 64'(snap));
    stall_prev = out_valid && !out_ready;
    snap = o;
    if (in_valid && !in_ready) saw_block = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        last_lat = cyc + 1 - acc_q.pop_front();
        check_eq("qmax", 64'(o[EW-1:5]), 64'(e[EW-1:5]));
        check_eq("greedy_action", 64'(o[4:3]), 64'(e[4:3]));
        check_eq("action", 64'(o[2:1]), 64'(e[2:1]));
        check_eq("explored", 64'(o[0]), 64'(e[0]));
        n_out++;
        last_out = o;
      end
    end
    if (in_valid && in_ready) begin
      ex = explore_en && (mdl_lfsr[7:0] < epsilon);
      a = ex ? mdl_lfsr[9:8] : cur_greedy;
      exp_q.push_back({cur_qmax, cur_greedy, a, ex});
      acc_q.push_back(cyc + 1);
      mdl_lfsr = lfsr_step(mdl_lfsr);
      acc = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // drives one vector until accepted; leaves in_valid high for back-to-back use
  task automatic send(input int a, input int b, input int c, input int d,
                      input logic en, input logic [7:0] eps,
                      input int mq, input logic [1:0] mg);
    bit acc;
    bit done;
    done = 1'b0;
    q0 = a; q1 = b; q2 = c; q3 = d;
    explore_en = en;
    epsilon = eps;
    cur_qmax = mq;
    cur_greedy = mg;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(acc);
      if (acc) done = 1'b1;
    end
    if (!done) check_eq("accept_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(acc);
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bit acc;
    int sent;
    int out0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_action", 64'(action), 64'(0));
    check_eq("rst_qmax", 64'($unsigned(qmax)), 64'(0));
    check_eq("rst_greedy", 64'(greedy_action), 64'(0));
    check_eq("rst_explored", 64'(explored), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));

    // basic latency: {5,-3,12,7} -> qmax 12, action 2
    out_ready = 1'b1;
    q0 = 5; q1 = -3; q2 = 12; q3 = 7;
    explore_en = 1'b0;
    epsilon = 8'd0;
    cur_qmax = 12;
    cur_greedy = 2'd2;
    in_valid = 1'b1;
    tick(acc);
    check_eq("t1_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    check_eq("lat_stage1", 64'(out_valid), 64'(0));
    tick(acc);
    check_eq("lat_stage2", 64'(out_valid), 64'(1));
    check_eq("t1_qmax", 64'($unsigned(qmax)), 64'(12));
    check_eq("t1_action", 64'(action), 64'(2));
    tick(acc);
    check_eq("t1_latency", 64'(last_lat), 64'(2));

    // signed values and ties
    send(-1, -1, -8, 32'h80000000, 1'b0, 8'd0, -1, 2'd0);
    send(3, 9, 9, 9, 1'b0, 8'd0, 9, 2'd1);
    drain();
    check_eq("tie_action", 64'(last_out[2:1]), 64'(1));

    // exploration: epsilon 255, 8 back-to-back beats
    for (int i = 1; i <= 8; i++) send(i, 2 * i, 3 * i, -i, 1'b1, 8'd255, 3 * i, 2'd2);
    // epsilon 0 never explores; explore_en 0 forces greedy
    for (int i = 1; i <= 4; i++) send(-i, 7, i, 0, 1'b1, 8'd0, 7, 2'd1);
    for (int i = 1; i <= 4; i++) send(0, 0, 0, i, 1'b0, 8'd255, i, 2'd3);
    drain();

    // backpressure: 6 beats, out_ready low for 3 cycles mid-stream
    saw_block = 1'b0;
    sent = 0;
    out0 = n_out;
    explore_en = 1'b1;
    epsilon = 8'd255;
    for (int k = 0; k < 40 && sent < 6; k++) begin
      out_ready = !(k >= 3 && k <= 5);
      in_valid = 1'b1;
      q0 = tq[sent][0]; q1 = tq[sent][1]; q2 = tq[sent][2]; q3 = tq[sent][3];
      cur_qmax = tm[sent];
      cur_greedy = tg[sent];
      tick(acc);
      if (acc) sent++;
    end
    drain();
    check_eq("bp_sent", 64'(sent), 64'(6));
    check_eq("bp_results", 64'(n_out - out0), 64'(6));
    check_eq("bp_in_ready_dropped", 64'(saw_block), 64'(1));

    // reset with both stages full
    out_ready = 1'b0;
    send(1, 2, 3, 4, 1'b0, 8'd0, 4, 2'd3);
    send(4, 3, 2, 1, 1'b0, 8'd0, 4, 2'd0);
    in_valid = 1'b0;
    check_eq("full_out_valid", 64'(out_valid), 64'(1));
    check_eq("full_in_ready", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("async_rst_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    acc_q.delete();
    mdl_lfsr = SEED;
    stall_prev = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    // seed 0xACE1: low byte 0xE1 < 255 explores, bits [9:8] = 0
    send(0, 0, 0, 100, 1'b1, 8'd255, 100, 2'd3);
    drain();
    check_eq("seed_action", 64'(last_out[2:1]), 64'(0));
    check_eq("seed_explored", 64'(last_out[0]), 64'(1));
    check_eq("seed_greedy", 64'(last_out[4:3]), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
